// File: rtl/otg_hpi_bridge_if.sv
// Avalon-MM slave and EZ-OTG HPI pad-side signal bundle for otg_hpi_bridge.
interface otg_hpi_bridge_if;
    logic [1:0]  avs_address;
    logic        avs_chipselect;
    logic        avs_read;
    logic        avs_write;
    logic [15:0] avs_writedata;
    logic [15:0] avs_readdata;
    logic        avs_waitrequest;
    logic [1:0]  hpi_addr;
    logic        hpi_cs_n;
    logic        hpi_rd_n;
    logic        hpi_wr_n;
    logic [15:0] hpi_data_out;
    logic        hpi_data_oe;
    logic [15:0] hpi_data_in;

    modport slave (
        input  avs_address, avs_chipselect, avs_read, avs_write, avs_writedata, hpi_data_in,
        output avs_readdata, avs_waitrequest, hpi_addr, hpi_cs_n, hpi_rd_n, hpi_wr_n,
        hpi_data_out, hpi_data_oe
    );

    modport master (
        output avs_address, avs_chipselect, avs_read, avs_write, avs_writedata, hpi_data_in,
        input  avs_readdata, avs_waitrequest, hpi_addr, hpi_cs_n, hpi_rd_n, hpi_wr_n,
        hpi_data_out, hpi_data_oe
    );
endinterface

// File: rtl/otg_hpi_bridge.sv
// Runs one timed EZ-OTG HPI cycle (setup/strobe/hold/recovery) per Avalon access.
// Optional macro OTG_HPI_INPUT_SYNC_EN adds a 2-flop synchronizer on hpi_data_in.
module otg_hpi_bridge #(
    parameter int SETUP_CYC    = 1,
    parameter int STROBE_CYC   = 4,
    parameter int HOLD_CYC     = 2,
    parameter int RECOVERY_CYC = 2
) (
    input  logic            clk,
    input  logic            reset,
    otg_hpi_bridge_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE, RECOVER} state_t;

    if (SETUP_CYC < 1 || SETUP_CYC > 15 || STROBE_CYC < 1 || STROBE_CYC > 15 ||
        HOLD_CYC < 1 || HOLD_CYC > 15 || RECOVERY_CYC < 1 || RECOVERY_CYC > 15) begin : g_range
        $error("otg_hpi_bridge: timing parameters must be in 1..15");
    end

    function automatic logic [3:0] reload(input int cycles);
        return 4'(cycles - 1);
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        dir_wr_q, dir_wr_d;
    logic [15:0] rdata_q, rdata_d;
    logic        cs_n_q, cs_n_d;
    logic        rd_n_q, rd_n_d;
    logic        wr_n_q, wr_n_d;
    logic        oe_q, oe_d;
    logic        req;
    logic        active_d;

`ifdef OTG_HPI_INPUT_SYNC_EN
    logic [15:0] sync1_q, sync2_q;

    if (HOLD_CYC < 2) begin : g_hold_chk
        $error("otg_hpi_bridge: OTG_HPI_INPUT_SYNC_EN needs HOLD_CYC >= 2");
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.hpi_data_in;
            sync2_q <= sync1_q;
        end
    end
`endif

    assign req                 = bus.avs_chipselect & (bus.avs_read | bus.avs_write);
    assign bus.avs_waitrequest = req & (state_q != DONE);
    assign bus.avs_readdata    = (state_q == DONE) ? rdata_q : '0;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        dir_wr_d = dir_wr_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d   = bus.avs_address;
                    wdata_d  = bus.avs_writedata;
                    dir_wr_d = ~bus.avs_read;
                    rdata_d  = '0;
                    cnt_d    = reload(SETUP_CYC);
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == 4'd0) begin
                    cnt_d   = reload(STROBE_CYC);
                    state_d = STROBE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
`ifndef OTG_HPI_INPUT_SYNC_EN
                    if (!dir_wr_q) rdata_d = bus.hpi_data_in;
`endif
                    cnt_d   = reload(HOLD_CYC);
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
`ifdef OTG_HPI_INPUT_SYNC_EN
                // The synchronizer delays the last-strobe sample by two cycles.
                if (!dir_wr_q && cnt_q == 4'(HOLD_CYC - 2)) rdata_d = sync2_q;
`endif
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                cnt_d   = reload(RECOVERY_CYC);
                state_d = RECOVER;
            end
            RECOVER: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pad controls are registered from the next state so they line up with it.
        active_d = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
        cs_n_d   = ~active_d;
        rd_n_d   = ~((state_d == STROBE) && !dir_wr_d);
        wr_n_d   = ~((state_d == STROBE) && dir_wr_d);
        oe_d     = active_d & dir_wr_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            dir_wr_q <= 1'b0;
            rdata_q  <= '0;
            cs_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            oe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            dir_wr_q <= dir_wr_d;
            rdata_q  <= rdata_d;
            cs_n_q   <= cs_n_d;
            rd_n_q   <= rd_n_d;
            wr_n_q   <= wr_n_d;
            oe_q     <= oe_d;
        end
    end

    assign bus.hpi_addr     = addr_q;
    assign bus.hpi_data_out = wdata_q;
    assign bus.hpi_cs_n     = cs_n_q;
    assign bus.hpi_rd_n     = rd_n_q;
    assign bus.hpi_wr_n     = wr_n_q;
    assign bus.hpi_data_oe  = oe_q;
endmodule

// File: tb/tb_otg_hpi_bridge.sv
// Scoreboard bench for otg_hpi_bridge: default timing on dut0, short timing on dut1.
module tb_otg_hpi_bridge;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  addr;
    logic        cs, rd, wr;
    logic [15:0] wdata, pin;

`ifdef OTG_HPI_INPUT_SYNC_EN
    localparam int H1 = 2;
`else
    localparam int H1 = 1;
`endif

    otg_hpi_bridge_if bus0 ();
    otg_hpi_bridge_if bus1 ();

    assign bus0.avs_address    = addr;
    assign bus0.avs_chipselect = cs;
    assign bus0.avs_read       = rd;
    assign bus0.avs_write      = wr;
    assign bus0.avs_writedata  = wdata;
    assign bus0.hpi_data_in    = pin;
    assign bus1.avs_address    = addr;
    assign bus1.avs_chipselect = cs;
    assign bus1.avs_read       = rd;
    assign bus1.avs_write      = wr;
    assign bus1.avs_writedata  = wdata;
    assign bus1.hpi_data_in    = pin;

    otg_hpi_bridge dut0 (.clk(clk), .reset(reset), .bus(bus0));
    otg_hpi_bridge #(.SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(H1), .RECOVERY_CYC(1))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));

    logic        sel;
    logic        o_wait, o_cs_n, o_rd_n, o_wr_n, o_oe;
    logic [1:0]  o_addr;
    logic [15:0] o_rdata, o_dout;

    assign o_wait  = sel ? bus1.avs_waitrequest : bus0.avs_waitrequest;
    assign o_rdata = sel ? bus1.avs_readdata    : bus0.avs_readdata;
    assign o_cs_n  = sel ? bus1.hpi_cs_n        : bus0.hpi_cs_n;
    assign o_rd_n  = sel ? bus1.hpi_rd_n        : bus0.hpi_rd_n;
    assign o_wr_n  = sel ? bus1.hpi_wr_n        : bus0.hpi_wr_n;
    assign o_oe    = sel ? bus1.hpi_data_oe     : bus0.hpi_data_oe;
    assign o_addr  = sel ? bus1.hpi_addr        : bus0.hpi_addr;
    assign o_dout  = sel ? bus1.hpi_data_out    : bus0.hpi_data_out;

    int total = 0;
    int bad   = 0;
    int ps, pt, ph;
    logic [15:0] sb_q[$];
    int m_lat, m_csf, m_cscnt, m_sf, m_scnt, m_oe, m_badaddr, m_baddout, m_other;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One Avalon access; measurements are relative to the cycle the request appears.
    task automatic access(input logic [1:0] a, input bit w, input logic [15:0] d,
                          input logic [15:0] val, input bit both);
        int  k;
        bit  done;
        logic strobe, other;
        sb_q.push_back(w ? 16'h0000 : val);
        @(posedge clk); #1;
        addr = a; cs = 1'b1; wr = w | both; rd = ~w | both; wdata = d; pin = val;
        m_lat = -1; m_csf = -1; m_cscnt = 0; m_sf = -1; m_scnt = 0;
        m_oe = 0; m_badaddr = 0; m_baddout = 0; m_other = 0;
        k = 0; done = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            if (!o_cs_n) begin
                m_cscnt++;
                if (m_csf < 0) m_csf = k;
                if (o_addr !== a) m_badaddr++;
            end
            strobe = w ? o_wr_n : o_rd_n;
            other  = w ? o_rd_n : o_wr_n;
            if (!strobe) begin
                m_scnt++;
                if (m_sf < 0) m_sf = k;
            end
            if (!other) m_other++;
            if (o_oe) begin
                m_oe++;
                if (o_dout !== d) m_baddout++;
            end
            if (!o_wait) begin
                m_lat = k;
                done  = 1;
                chk("readdata", {16'h0, o_rdata}, {16'h0, sb_q.pop_front()});
            end else begin
                @(posedge clk); #1;
                k++;
                pin = (m_scnt < pt) ? val : 16'h0F0F;
            end
        end
        if (!done) begin
            chk("timeout", 32'd0, 32'd1);
            void'(sb_q.pop_front());
        end
    endtask

    task automatic release_bus();
        @(posedge clk); #1;
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        cs = 1'b0; rd = 1'b0; wr = 1'b0; reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic check_timing(input string tag, input bit w);
        chk({tag, "_lat"},    m_lat,    1 + ps + pt + ph);
        chk({tag, "_csf"},    m_csf,    1);
        chk({tag, "_cscnt"},  m_cscnt,  ps + pt + ph);
        chk({tag, "_sf"},     m_sf,     1 + ps);
        chk({tag, "_scnt"},   m_scnt,   pt);
        chk({tag, "_oe"},     m_oe,     w ? ps + pt + ph : 0);
        chk({tag, "_addr"},   m_badaddr, 0);
        chk({tag, "_dout"},   m_baddout, 0);
        chk({tag, "_other"},  m_other,  0);
    endtask

    initial begin
        int lat1, csf1, n;
        sel = 1'b0; ps = 1; pt = 4; ph = 2;
        addr = '0; cs = 1'b0; rd = 1'b0; wr = 1'b0; wdata = '0; pin = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_cs_n",  o_cs_n,  1);
        chk("rst_rd_n",  o_rd_n,  1);
        chk("rst_wr_n",  o_wr_n,  1);
        chk("rst_oe",    o_oe,    0);
        chk("rst_addr",  o_addr,  0);
        chk("rst_dout",  o_dout,  0);
        chk("rst_rdata", o_rdata, 0);
        chk("rst_wait",  o_wait,  0);

        access(2'd2, 1'b1, 16'h1234, 16'h0000, 1'b0);
        check_timing("wr", 1'b1);
        release_bus();
        repeat (4) @(posedge clk);

        access(2'd0, 1'b0, 16'h0000, 16'hBEEF, 1'b0);
        check_timing("rd", 1'b0);
        release_bus();
        repeat (4) @(posedge clk);

        access(2'd1, 1'b0, 16'h7777, 16'h5A5A, 1'b1);
        check_timing("both", 1'b0);
        release_bus();
        repeat (4) @(posedge clk);

        // Write immediately followed by a read with the request never dropped.
        access(2'd3, 1'b1, 16'hA55A, 16'h0000, 1'b0);
        lat1 = m_lat; csf1 = m_csf;
        access(2'd0, 1'b0, 16'h0000, 16'hC3C3, 1'b0);
        chk("b2b_period", lat1 + 1 + m_csf - csf1, 2 + ps + pt + ph + 2);
        chk("b2b_cscnt",  m_cscnt, ps + pt + ph);
        release_bus();
        repeat (4) @(posedge clk);

        // Request withdrawn after the access started: HPI cycle still completes.
        @(posedge clk); #1;
        addr = 2'd1; cs = 1'b1; wr = 1'b1; rd = 1'b0; wdata = 16'h4242;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (!o_cs_n) n++;
            if (i == 1) begin
                @(posedge clk); #1;
                cs = 1'b0; wr = 1'b0;
            end
        end
        chk("drop_cscnt", n, ps + pt + ph);
        access(2'd2, 1'b0, 16'h0000, 16'h2468, 1'b0);
        chk("drop_next_lat", m_lat, 1 + ps + pt + ph);
        release_bus();
        repeat (4) @(posedge clk);

        // Reset asserted while the write strobe is low.
        @(posedge clk); #1;
        addr = 2'd2; cs = 1'b1; wr = 1'b1; rd = 1'b0; wdata = 16'h9999;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_wr_n && n < 20);
        chk("mid_strobe_seen", o_wr_n, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_wr_n", o_wr_n, 1);
        chk("mid_rst_cs_n", o_cs_n, 1);
        chk("mid_rst_oe",   o_oe,   0);
        cs = 1'b0; wr = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_wait", o_wait, 0);
        access(2'd0, 1'b0, 16'h0000, 16'h1111, 1'b0);
        chk("post_rst_lat", m_lat, 1 + ps + pt + ph);
        release_bus();

        // Short-timing instance.
        do_reset();
        sel = 1'b1; ps = 2; pt = 1; ph = H1;
        access(2'd2, 1'b1, 16'hCAFE, 16'h0000, 1'b0);
        check_timing("p_wr", 1'b1);
        release_bus();
        repeat (3) @(posedge clk);
        access(2'd3, 1'b0, 16'h0000, 16'h1357, 1'b0);
        check_timing("p_rd", 1'b0);
        release_bus();
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
